// File: rtl/audio_mixer_sd.sv
// N-channel stereo mixer: snapshots channels and per-side gains on a strobe,
// accumulates one channel per clock, saturates, and drives a first-order sigma-delta DAC per side.
module audio_mixer_sd #(
  parameter int NCH   = 4,
  parameter int IW    = 8,
  parameter int GW    = 5,
  parameter int SHIFT = 4,
  parameter int OW    = 9
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                sample_stb,
  input  logic [NCH*IW-1:0]   ch_data,
  input  logic [NCH*GW-1:0]   gain_l,
  input  logic [NCH*GW-1:0]   gain_r,
  input  logic                mute,
  output logic [OW-1:0]       mix_left,
  output logic [OW-1:0]       mix_right,
  output logic                mix_valid,
  output logic                busy,
  output logic                clip_left,
  output logic                clip_right,
  output logic                overrun,
  output logic                audio_out_left,
  output logic                audio_out_right
);

  localparam int PW = IW + GW;
  localparam int AW = PW + $clog2(NCH) + 1;
  localparam int XW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = OW + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_SAT  = 2'd2;

  localparam logic [XW-1:0] LAST_IDX = XW'(NCH - 1);
  localparam logic [AW-1:0] MIX_MAX  = AW'((1 << OW) - 1);
  localparam logic [DW-1:0] SIG_INIT = DW'(1) << OW;

  logic [1:0]          state;
  logic [XW-1:0]       idx;
  logic [NCH*IW-1:0]   snap_ch;
  logic [NCH*GW-1:0]   snap_gl;
  logic [NCH*GW-1:0]   snap_gr;
  logic [AW-1:0]       acc_l;
  logic [AW-1:0]       acc_r;

  logic [IW-1:0]       cur_ch;
  logic [GW-1:0]       cur_gl;
  logic [GW-1:0]       cur_gr;
  logic [PW-1:0]       prod_l;
  logic [PW-1:0]       prod_r;
  logic [AW-1:0]       res_l;
  logic [AW-1:0]       res_r;
  logic                sat_l;
  logic                sat_r;
  logic [OW-1:0]       din_l;
  logic [OW-1:0]       din_r;

  logic [DW-1:0]       sig_l;
  logic [DW-1:0]       sig_r;
  logic [DW-1:0]       delta_l;
  logic [DW-1:0]       delta_r;

  assign busy = (state != S_IDLE);

  assign cur_ch = snap_ch[idx*IW +: IW];
  assign cur_gl = snap_gl[idx*GW +: GW];
  assign cur_gr = snap_gr[idx*GW +: GW];
  assign prod_l = {{GW{1'b0}}, cur_ch} * {{IW{1'b0}}, cur_gl};
  assign prod_r = {{GW{1'b0}}, cur_ch} * {{IW{1'b0}}, cur_gr};

  always_comb begin
    // NOTE: every variable gets a value before any condition, so no latch is inferred.
    res_l = acc_l >> SHIFT;
    res_r = acc_r >> SHIFT;
    sat_l = 1'b0;
    sat_r = 1'b0;
    if (res_l > MIX_MAX) sat_l = 1'b1;
    if (res_r > MIX_MAX) sat_r = 1'b1;
    din_l = mute ? '0 : mix_left;
    din_r = mute ? '0 : mix_right;
  end

  // NOTE: the snapshot is pure datapath, always loaded before it is read, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (state == S_IDLE && sample_stb) begin
      snap_ch <= ch_data;
      snap_gl <= gain_l;
      snap_gr <= gain_r;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      mix_left   <= '0;
      mix_right  <= '0;
      mix_valid  <= 1'b0;
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      // A strobe during any busy cycle, SAT included, is dropped but remembered.
      if (sample_stb && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (sample_stb) begin
            acc_l <= '0;
            acc_r <= '0;
            idx   <= '0;
            state <= S_ACC;
          end
        end
        S_ACC: begin
          acc_l <= acc_l + AW'(prod_l);
          acc_r <= acc_r + AW'(prod_r);
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) state <= S_SAT;
        end
        S_SAT: begin
          mix_left   <= sat_l ? '1 : res_l[OW-1:0];
          mix_right  <= sat_r ? '1 : res_r[OW-1:0];
          clip_left  <= clip_left | sat_l;
          clip_right <= clip_right | sat_r;
          mix_valid  <= 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Feedback of both top bits subtracts 2^OW (mod 2^(OW+2)) per emitted one,
  // giving a ones density of din / 2^OW.
  assign delta_l = {sig_l[DW-1], sig_l[DW-1], {OW{1'b0}}};
  assign delta_r = {sig_r[DW-1], sig_r[DW-1], {OW{1'b0}}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sig_l           <= SIG_INIT;
      sig_r           <= SIG_INIT;
      audio_out_left  <= 1'b0;
      audio_out_right <= 1'b0;
    end else begin
      sig_l           <= sig_l + {2'b00, din_l} + delta_l;
      sig_r           <= sig_r + {2'b00, din_r} + delta_r;
      audio_out_left  <= sig_l[DW-1];
      audio_out_right <= sig_r[DW-1];
    end
  end

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Directed bench for audio_mixer_sd: scoreboard of expected mixes checked on mix_valid,
// plus timing, sticky-flag, abort and DAC density checks.
module tb_audio_mixer_sd;

  localparam int NCH   = 4;
  localparam int IW    = 8;
  localparam int GW    = 5;
  localparam int SHIFT = 4;
  localparam int OW    = 9;
  localparam int LAT   = NCH + 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              sample_stb;
  logic [NCH*IW-1:0] ch_data;
  logic [NCH*GW-1:0] gain_l;
  logic [NCH*GW-1:0] gain_r;
  logic              mute;
  logic [OW-1:0]     mix_left;
  logic [OW-1:0]     mix_right;
  logic              mix_valid;
  logic              busy;
  logic              clip_left;
  logic              clip_right;
  logic              overrun;
  logic              audio_out_left;
  logic              audio_out_right;

  audio_mixer_sd #(.NCH(NCH), .IW(IW), .GW(GW), .SHIFT(SHIFT), .OW(OW)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .sample_stb      (sample_stb),
    .ch_data         (ch_data),
    .gain_l          (gain_l),
    .gain_r          (gain_r),
    .mute            (mute),
    .mix_left        (mix_left),
    .mix_right       (mix_right),
    .mix_valid       (mix_valid),
    .busy            (busy),
    .clip_left       (clip_left),
    .clip_right      (clip_right),
    .overrun         (overrun),
    .audio_out_left  (audio_out_left),
    .audio_out_right (audio_out_right)
  );

  always #5 Clk = ~Clk;

  typedef int vec_t[NCH];
  typedef struct {
    int l;
    int r;
    bit cl;
    bit cr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_valid  = 0;
  bit   model_clip_l = 1'b0;
  bit   model_clip_r = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    n_checks++;
    assert (obs >= exp - tol && obs <= exp + tol) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d +- %0d", tag, obs, exp, tol);
  endtask

  function automatic int mix_model(input vec_t ch, input vec_t g, output bit sat);
    int acc = 0;
    for (int k = 0; k < NCH; k++) acc += ch[k] * g[k];
    acc = acc >> SHIFT;
    sat = (acc > (1 << OW) - 1);
    return sat ? (1 << OW) - 1 : acc;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive(input vec_t ch, input vec_t gl, input vec_t gr);
    for (int k = 0; k < NCH; k++) begin
      ch_data[k*IW +: IW] = IW'(ch[k]);
      gain_l[k*GW +: GW]  = GW'(gl[k]);
      gain_r[k*GW +: GW]  = GW'(gr[k]);
    end
  endtask

  // Queues the expected result, then issues a one-cycle strobe; returns just after E0.
  task automatic start_pass(input vec_t ch, input vec_t gl, input vec_t gr);
    exp_t e;
    bit   sl;
    bit   sr;
    e.l = mix_model(ch, gl, sl);
    e.r = mix_model(ch, gr, sr);
    model_clip_l = model_clip_l | sl;
    model_clip_r = model_clip_r | sr;
    e.cl = model_clip_l;
    e.cr = model_clip_r;
    sb.push_back(e);
    drive(ch, gl, gr);
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
  endtask

  // Waits (bounded) for mix_valid, checking latency and the busy window on the way.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    int bsy = 0;
    while (mix_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bsy++;
      tick(1);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bsy, exp_lat);
    check({tag, "_busy_at_valid"}, busy, 0);
    tick(1);
    check({tag, "_valid_pulse"}, mix_valid, 0);
  endtask

  task automatic count_ones(input int n, output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (n) begin
      @(negedge Clk);
      if (audio_out_left === 1'b1) cl++;
      if (audio_out_right === 1'b1) cr++;
    end
    tick(1);
  endtask

  // Scoreboard consumer: every mix_valid must match the oldest pending expectation.
  always @(negedge Clk) begin
    if (mix_valid === 1'b1) begin
      n_valid++;
      check("pending_on_valid", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("mix_left", mix_left, mon_e.l);
        check("mix_right", mix_right, mon_e.r);
        check("clip_left", clip_left, mon_e.cl);
        check("clip_right", clip_right, mon_e.cr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t g16;
    vec_t g31;
    vec_t g0;
    int   cl;
    int   cr;
    int   nv;
    g16 = '{16, 16, 16, 16};
    g31 = '{31, 31, 31, 31};
    g0  = '{0, 0, 0, 0};

    // Reset held three clocks with random inputs.
    Reset = 1'b1;
    mute  = 1'b0;
    repeat (3) begin
      sample_stb = 1'($urandom_range(0, 1));
      ch_data    = $urandom;
      gain_l     = NCH*GW'($urandom);
      gain_r     = NCH*GW'($urandom);
      tick(1);
    end
    check("reset_outputs",
          {mix_left, mix_right, mix_valid, busy, clip_left, clip_right, overrun,
           audio_out_left, audio_out_right}, 0);
    Reset      = 1'b0;
    sample_stb = 1'b0;
    drive(g0, g0, g0);
    count_ones(32, cl, cr);
    check("idle_dac_left", cl, 0);
    check("idle_dac_right", cr, 0);
    check("idle_busy", busy, 0);

    // Unity gains, four distinct channels.
    start_pass('{10, 20, 30, 40}, g16, g16);
    wait_valid("basic", LAT);
    check("basic_no_overrun", overrun, 0);

    // Hard pan.
    start_pass('{200, 0, 0, 60}, '{16, 0, 0, 0}, '{0, 0, 0, 16});
    wait_valid("pan", LAT);

    // DAC at mix = 128.
    start_pass('{128, 0, 0, 0}, g16, g16);
    wait_valid("dac128", LAT);
    tick(4);
    count_ones(8192, cl, cr);
    check_near("dac128_ones_left", cl, 2048, 1);
    check_near("dac128_ones_right", cr, 2048, 1);

    // Full-scale saturation, then DAC at mix = 511.
    start_pass('{255, 255, 255, 255}, g31, g31);
    wait_valid("sat", LAT);
    tick(4);
    count_ones(8192, cl, cr);
    check_near("dac511_ones_left", cl, 8176, 1);
    check_near("dac511_ones_right", cr, 8176, 1);

    // Clip flags stay set through a clean pass.
    start_pass('{10, 20, 30, 40}, g16, g16);
    wait_valid("after_sat", LAT);

    // Mute silences both DACs within two clocks.
    mute = 1'b1;
    tick(2);
    count_ones(64, cl, cr);
    check("mute_ones_left", cl, 0);
    check("mute_ones_right", cr, 0);
    mute = 1'b0;

    // Strobe during the SAT cycle is dropped.
    start_pass('{1, 2, 3, 4}, g16, g16);
    tick(NCH);
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
    check("sat_stb_valid", mix_valid, 1);
    check("sat_stb_overrun", overrun, 1);
    check("sat_stb_not_started", busy, 0);
    tick(1);
    check("sat_stb_still_idle", busy, 0);
    tick(2);

    // Inputs changed after E0 must not reach the result.
    start_pass('{50, 60, 70, 80}, g16, '{8, 8, 8, 8});
    tick(1);
    drive('{255, 255, 255, 255}, g31, g31);
    wait_valid("snapshot", LAT - 1);
    drive(g0, g0, g0);

    // Reset in the middle of accumulation aborts the pass.
    start_pass('{10, 20, 30, 40}, g16, g16);
    tick(1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    sb.delete();
    model_clip_l = 1'b0;
    model_clip_r = 1'b0;
    nv = n_valid;
    check("abort_state",
          {busy, mix_valid, clip_left, clip_right, overrun, mix_left, mix_right}, 0);
    tick(8);
    check("abort_no_valid", n_valid, nv);

    // Strobe at busy cycle 2 is dropped; the running pass completes normally.
    start_pass('{200, 0, 0, 60}, '{16, 0, 0, 0}, '{0, 0, 0, 16});
    tick(1);
    sample_stb = 1'b1;
    tick(1);
    sample_stb = 1'b0;
    check("busy2_overrun", overrun, 1);
    wait_valid("busy2", LAT - 2);

    tick(4);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
